cache2way_ctrl: RTL

//   Sequencing controller for the 2-way set-associative cache (via1/via2, 8 sets x 12b) and the 32x8 backing RAM.

---
 rtl/cache_pkg.sv | 30 +++
 rtl/cache_line_update.sv | 73 +++++++
 rtl/cache2way_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared state encoding and cache-line field layout for the 2-way cache controller.
// Line layout: {valid, lru, tag[1:0], data[7:0]}; lru=1 marks the way to replace next.
package cache_pkg;

  typedef enum logic [1:0] {INIT, IDLE, LOOKUP, RESP} state_t;

  localparam int VALID_BIT = 11;
  localparam int LRU_BIT   = 10;
  localparam int TAG_MSB   = 9;
  localparam int TAG_LSB   = 8;
  localparam int DATA_MSB  = 7;
  localparam int DATA_LSB  = 0;
  localparam int SETS      = 8;
  localparam int LINE_W    = 12;
  localparam int WAYS      = 2;
  localparam int IDX_W     = 3;
  localparam int TAG_W     = 2;
  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 5;

  function automatic logic [LINE_W-1:0] make_line(
    input logic              valid,
    input logic              lru,
    input logic [TAG_W-1:0]  tag,
    input logic [DATA_W-1:0] data
  );
    return {valid, lru, tag, data};
  endfunction

endpackage

// File: rtl/cache_line_update.sv
// Combinational hit detection, victim choice and next-line construction for both ways.
// WRITE_ALLOCATE_EN: when defined, a write miss fills the victim way; otherwise it leaves both ways alone.
module cache_line_update
  import cache_pkg::*;
(
  input  logic [LINE_W-1:0] i_via1_q,
  input  logic [LINE_W-1:0] i_via2_q,
  input  logic [TAG_W-1:0]  i_tag,
  input  logic              i_write,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] i_ram_q,
  output logic              o_hit,
  output logic [DATA_W-1:0] o_data,
  output logic [LINE_W-1:0] o_via1_line,
  output logic [LINE_W-1:0] o_via2_line,
  output logic              o_via1_wren,
  output logic              o_via2_wren
);

  logic [LINE_W-1:0] w_q    [WAYS];
  logic [LINE_W-1:0] w_line [WAYS];
  logic [WAYS-1:0]   w_hit;
  logic [WAYS-1:0]   w_valid;
  logic [WAYS-1:0]   w_lru;
  logic [DATA_W-1:0] w_hit_data;
  logic              w_hit_way;
  logic              w_victim;
  logic              w_target;
  logic              w_update;

  assign w_q[0] = i_via1_q;
  assign w_q[1] = i_via2_q;

  // The touched way becomes most-recent; the other way is marked for replacement.
  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_way
      assign w_valid[gi] = w_q[gi][VALID_BIT];
      assign w_lru[gi]   = w_q[gi][LRU_BIT];
      assign w_hit[gi]   = w_valid[gi] && (w_q[gi][TAG_MSB:TAG_LSB] == i_tag);
      assign w_line[gi]  = (int'(w_target) == gi)
                         ? make_line(1'b1, 1'b0, i_tag, o_data)
                         : {w_q[gi][VALID_BIT], 1'b1, w_q[gi][TAG_MSB:DATA_LSB]};
    end
  endgenerate

  assign o_hit      = |w_hit;
  assign w_hit_way  = ~w_hit[0];
  assign w_hit_data = w_hit[0] ? w_q[0][DATA_MSB:DATA_LSB] : w_q[1][DATA_MSB:DATA_LSB];

  always_comb begin
    if (!w_valid[0])      w_victim = 1'b0;
    else if (!w_valid[1]) w_victim = 1'b1;
    else if (w_lru[0])    w_victim = 1'b0;
    else if (w_lru[1])    w_victim = 1'b1;
    else                  w_victim = 1'b0;
  end

  assign o_data   = i_write ? i_wdata : (o_hit ? w_hit_data : i_ram_q);
  assign w_target = o_hit ? w_hit_way : w_victim;

`ifdef WRITE_ALLOCATE_EN
  assign w_update = 1'b1;
`else
  assign w_update = o_hit | ~i_write;
`endif

  assign o_via1_line = w_line[0];
  assign o_via2_line = w_line[1];
  assign o_via1_wren = w_update;
  assign o_via2_wren = w_update;

endmodule

// File: rtl/cache2way_ctrl.sv
// Sequencing controller for a 2-way, 8-set cache with write-through to a 32x8 RAM.
// Write-miss allocation is selected by WRITE_ALLOCATE_EN inside cache_line_update.
module cache2way_ctrl
  import cache_pkg::*;
#(
  parameter int CNT_W = 16
)
(
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_rsp_valid,
  output logic              o_rsp_hit,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic [IDX_W-1:0]  o_via_addr,
  output logic [LINE_W-1:0] o_via1_wdata,
  output logic [LINE_W-1:0] o_via2_wdata,
  output logic              o_via1_wren,
  output logic              o_via2_wren,
  input  logic [LINE_W-1:0] i_via1_q,
  input  logic [LINE_W-1:0] i_via2_q,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  output logic              o_ram_wren,
  input  logic [DATA_W-1:0] i_ram_q,
  output logic [CNT_W-1:0]  o_hit_count,
  output logic [CNT_W-1:0]  o_miss_count
);

  state_t            r_state;
  logic [IDX_W-1:0]  r_init_idx;
  logic              r_req_write;
  logic [ADDR_W-1:0] r_req_addr;
  logic [DATA_W-1:0] r_req_wdata;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic              r_rsp_hit;
  logic [DATA_W-1:0] r_rsp_data;
  logic [CNT_W-1:0]  r_hit_count;
  logic [CNT_W-1:0]  r_miss_count;

  logic              w_hit;
  logic [DATA_W-1:0] w_data;
  logic [LINE_W-1:0] w_via1_line;
  logic [LINE_W-1:0] w_via2_line;
  logic              w_upd1;
  logic              w_upd2;
  logic              w_in_init;
  logic              w_in_lookup;

  cache_line_update u_line_update (
    .i_via1_q    (i_via1_q),
    .i_via2_q    (i_via2_q),
    .i_tag       (r_req_addr[ADDR_W-1:IDX_W]),
    .i_write     (r_req_write),
    .i_wdata     (r_req_wdata),
    .i_ram_q     (i_ram_q),
    .o_hit       (w_hit),
    .o_data      (w_data),
    .o_via1_line (w_via1_line),
    .o_via2_line (w_via2_line),
    .o_via1_wren (w_upd1),
    .o_via2_wren (w_upd2)
  );

  // INIT is also the reset state, so its clear-sweep enables are held off while reset is low.
  assign w_in_init   = (r_state == INIT) && i_reset_n;
  assign w_in_lookup = (r_state == LOOKUP);

  // In IDLE the memories read the incoming address so q is ready in LOOKUP.
  always_comb begin
    o_via_addr = r_req_addr[IDX_W-1:0];
    o_ram_addr = r_req_addr;
    if (r_state == INIT) begin
      o_via_addr = r_init_idx;
    end else if (r_state == IDLE) begin
      o_via_addr = i_req_addr[IDX_W-1:0];
      o_ram_addr = i_req_addr;
    end
  end

  assign o_via1_wdata = w_in_lookup ? w_via1_line : '0;
  assign o_via2_wdata = w_in_lookup ? w_via2_line : '0;
  assign o_via1_wren  = w_in_init | (w_in_lookup & w_upd1);
  assign o_via2_wren  = w_in_init | (w_in_lookup & w_upd2);
  assign o_ram_wdata  = r_req_wdata;
  assign o_ram_wren   = w_in_lookup & r_req_write;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= INIT;
      r_init_idx   <= '0;
      r_req_write  <= 1'b0;
      r_req_addr   <= '0;
      r_req_wdata  <= '0;
      r_req_ready  <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_hit    <= 1'b0;
      r_rsp_data   <= '0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      case (r_state)
        INIT: begin
          r_init_idx <= r_init_idx + IDX_W'(1);
          if (r_init_idx == IDX_W'(SETS - 1)) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b1;
          end
        end
        IDLE: begin
          if (i_req_valid) begin
            r_req_write <= i_req_write;
            r_req_addr  <= i_req_addr;
            r_req_wdata <= i_req_wdata;
            r_req_ready <= 1'b0;
            r_state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          r_rsp_valid <= 1'b1;
          r_rsp_hit   <= w_hit;
          r_rsp_data  <= w_data;
          r_state     <= RESP;
        end
        RESP: begin
          r_rsp_valid <= 1'b0;
          if (r_rsp_hit) begin
            if (r_hit_count != '1) r_hit_count <= r_hit_count + CNT_W'(1);
          end else begin
            if (r_miss_count != '1) r_miss_count <= r_miss_count + CNT_W'(1);
          end
          r_req_ready <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= INIT;
      endcase
    end
  end

  assign o_req_ready  = r_req_ready;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_hit    = r_rsp_hit;
  assign o_rsp_data   = r_rsp_data;
  assign o_hit_count  = r_hit_count;
  assign o_miss_count = r_miss_count;

endmodule
